enigma_axi_regs: RTL and testbench

ENIGMA_AXI_REGS -- requirements
Module: enigma_axi_regs

---
 rtl/enigma_axi_regs.sv | 235 +++++++++++++++++++++++
 tb/tb_enigma_axi_regs.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_axi_regs.sv
// -----------------------------------------------------------------------------
// enigma_axi_regs
// AXI4-Lite slave that exposes four 32-bit configuration registers to the
// enigma core.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN : clock (rising edge) and async active-low reset
//   S_AXI_AW*                  : write address channel (one-deep buffer)
//   S_AXI_W*                   : write data channel (one-deep buffer)
//   S_AXI_B*                   : write response channel (always OKAY)
//   S_AXI_AR*                  : read address channel
//   S_AXI_R*                   : read data channel (always OKAY)
//   reg0_o..reg3_o             : current register contents
//   wr_pulse_o                 : one-hot, high for one cycle after a write commits
// -----------------------------------------------------------------------------
module enigma_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  // write response channel
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  // register contents and write strobes to the core
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
  output logic [3:0]                        wr_pulse_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  // Byte-lane merge: lanes with a strobe bit take the new value, others keep old.
  function automatic logic [DW-1:0] f_merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_v[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_v[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // Word index to one-hot write strobe.
  function automatic logic [3:0] f_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          r_rst_done;     // holds all READYs low until first edge after reset
  logic          r_aw_full;
  logic [1:0]    r_aw_idx;
  logic          r_w_full;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic          r_bvalid;
  logic [3:0]    r_wr_pulse;
  logic [DW-1:0] r_reg [0:3];
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;

  // ---------------------------------------------------------------------------
  // Combinational handshake / commit decode
  // ---------------------------------------------------------------------------
  logic          w_awready;
  logic          w_wready;
  logic          w_arready;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_ar_hs;
  logic          w_commit;
  logic [1:0]    w_wr_idx;
  logic [DW-1:0] w_wr_data;
  logic [SW-1:0] w_wr_strb;
  logic [1:0]    w_ar_idx;
  logic          w_unused;

  assign w_awready = r_rst_done & ~r_aw_full & ~r_bvalid;
  assign w_wready  = r_rst_done & ~r_w_full  & ~r_bvalid;
  assign w_arready = r_rst_done & ~r_rvalid;

  assign w_aw_hs   = S_AXI_AWVALID & w_awready;
  assign w_w_hs    = S_AXI_WVALID  & w_wready;
  assign w_ar_hs   = S_AXI_ARVALID & w_arready;

  // A write commits once both halves are present, buffered or arriving now.
  assign w_commit  = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
  assign w_ar_idx  = S_AXI_ARADDR[3:2];

  // Protection bits and byte-offset address bits carry no meaning here.
  assign w_unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Select write address/data from the buffer when full, else from the bus.
  always_comb begin
    w_wr_idx  = 2'b00;
    w_wr_data = {DW{1'b0}};
    w_wr_strb = {SW{1'b0}};
    if (r_aw_full) begin
      w_wr_idx = r_aw_idx;
    end else begin
      w_wr_idx = S_AXI_AWADDR[3:2];
    end
    if (r_w_full) begin
      w_wr_data = r_wdata;
      w_wr_strb = r_wstrb;
    end else begin
      w_wr_data = S_AXI_WDATA;
      w_wr_strb = S_AXI_WSTRB;
    end
  end

  // Write path: AW/W buffers, commit, response and write pulse.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rst_done <= 1'b0;
      r_aw_full  <= 1'b0;
      r_aw_idx   <= 2'b00;
      r_w_full   <= 1'b0;
      r_wdata    <= {DW{1'b0}};
      r_wstrb    <= {SW{1'b0}};
      r_bvalid   <= 1'b0;
      r_wr_pulse <= 4'b0000;
    end else begin
      r_rst_done <= 1'b1;
      if (w_commit) begin
        r_aw_full  <= 1'b0;
        r_w_full   <= 1'b0;
        r_bvalid   <= 1'b1;
        r_wr_pulse <= f_onehot(w_wr_idx);
      end else begin
        r_wr_pulse <= 4'b0000;
        // Buffers only fill here; they are held until the partner arrives.
        if (w_aw_hs) begin
          r_aw_full <= 1'b1;
          r_aw_idx  <= S_AXI_AWADDR[3:2];
        end
        if (w_w_hs) begin
          r_w_full <= 1'b1;
          r_wdata  <= S_AXI_WDATA;
          r_wstrb  <= S_AXI_WSTRB;
        end
        if (r_bvalid && S_AXI_BREADY) begin
          r_bvalid <= 1'b0;
        end
      end
    end
  end

  // Register file: byte-strobed update on commit.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        r_reg[i] <= {DW{1'b0}};
      end
    end else begin
      if (w_commit) begin
        r_reg[w_wr_idx] <= f_merge_bytes(r_reg[w_wr_idx], w_wr_data, w_wr_strb);
      end
    end
  end

  // Read path: capture on AR handshake (sees pre-commit value on a same-edge write).
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= {DW{1'b0}};
    end else begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= r_reg[w_ar_idx];
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= r_rvalid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign reg0_o        = r_reg[0];
  assign reg1_o        = r_reg[1];
  assign reg2_o        = r_reg[2];
  assign reg3_o        = r_reg[3];
  assign wr_pulse_o    = r_wr_pulse;

endmodule

// File: tb/tb_enigma_axi_regs.sv
// -----------------------------------------------------------------------------
// tb_enigma_axi_regs
// Self-checking bench for enigma_axi_regs. Read expectations are pushed to a
// queue when the AR is issued and popped when R data returns; a small model
// array tracks what each register should hold.
// -----------------------------------------------------------------------------
module tb_enigma_axi_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = 4'h0;
  logic [2:0]  awprot = 3'b000;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = 4'h0;
  logic [2:0]  arprot = 3'b000;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  wr_pulse;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_reg[4];

  enigma_axi_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg0_o        (reg0),
    .reg1_o        (reg1),
    .reg2_o        (reg2),
    .reg3_o        (reg3),
    .wr_pulse_o    (wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_reg0"}, reg0, m_reg[0]);
    check({tag, "_reg1"}, reg1, m_reg[1]);
    check({tag, "_reg2"}, reg2, m_reg[2]);
    check({tag, "_reg3"}, reg3, m_reg[3]);
  endtask

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) m_reg[addr[3:2]][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  // Called at a negedge; returns at a negedge with the B response consumed.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit hs_aw, hs_w, got_b;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clk);
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin wvalid  = 1'b0; w_done  = 1'b1; end
      if (aw_done && w_done) break;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_accept", {30'd0, aw_done, w_done}, 32'd3);
    model_write(addr, data, strb);
    bready = 1'b1;
    got_b  = 1'b0;
    for (int i = 0; i < 50 && !got_b; i++) begin
      if (bvalid) begin
        got_b = 1'b1;
        check("bresp", {30'd0, bresp}, 32'd0);
      end
      @(negedge clk);
    end
    bready = 1'b0;
    check("bvalid_seen", {31'd0, got_b}, 32'd1);
  endtask

  // Called at a negedge; expectation queued at AR issue, compared at R.
  task automatic axi_read(input logic [3:0] addr);
    bit ar_done = 1'b0;
    bit got_r   = 1'b0;
    logic [31:0] exp_v;
    exp_q.push_back(m_reg[addr[3:2]]);
    araddr = addr; arvalid = 1'b1;
    for (int i = 0; i < 50 && !ar_done; i++) begin
      ar_done = arready;
      @(negedge clk);
    end
    arvalid = 1'b0;
    check("ar_accept", {31'd0, ar_done}, 32'd1);
    rready = 1'b1;
    for (int i = 0; i < 50 && !got_r; i++) begin
      if (rvalid) begin
        got_r = 1'b1;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
        check("rdata", rdata, exp_v);
        check("rresp", {30'd0, rresp}, 32'd0);
      end
      @(negedge clk);
    end
    rready = 1'b0;
    check("rvalid_seen", {31'd0, got_r}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;

    // ---- reset state
    repeat (3) @(negedge clk);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_pulse",   {28'd0, wr_pulse}, 32'd0);
    check_regs("rst");
    rst_n = 1'b1;
    #1;
    check("rel_awready_pre", {31'd0, awready}, 32'd0);
    @(negedge clk);
    check("rel_awready", {31'd0, awready}, 32'd1);
    check("rel_wready",  {31'd0, wready},  32'd1);
    check("rel_arready", {31'd0, arready}, 32'd1);

    // ---- basic write / read-back of all four registers
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4));
    check_regs("basic");
    check("basic_reg3_const", reg3, 32'h4);

    // ---- AW at cycle 0, W at cycle 5
    awaddr = 4'h8; awvalid = 1'b1;
    check("late_awready0", {31'd0, awready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("late_awready", {31'd0, awready}, 32'd0);
      check("late_bvalid",  {31'd0, bvalid},  32'd0);
      check("late_pulse",   {28'd0, wr_pulse}, 32'd0);
      @(negedge clk);
    end
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    check("late_wready", {31'd0, wready}, 32'd1);
    @(negedge clk);
    wvalid = 1'b0;
    model_write(4'h8, 32'hDEADBEEF, 4'hF);
    check("late_bvalid6", {31'd0, bvalid}, 32'd1);
    check("late_pulse6",  {28'd0, wr_pulse}, 32'd4);
    check("late_reg2",    reg2, 32'hDEADBEEF);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("late_pulse7",  {28'd0, wr_pulse}, 32'd0);
    check("late_bvalid7", {31'd0, bvalid}, 32'd0);

    // ---- byte strobes
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF);
    axi_write(4'h4, 32'h00000000, 4'b0101);
    check("strb_reg1", reg1, 32'hFF00FF00);
    axi_read(4'h4);
    axi_write(4'h4, 32'h12345678, 4'b0000);
    check("strb0_reg1", reg1, 32'hFF00FF00);

    // ---- BREADY held low: no new write accepted
    awaddr = 4'h0; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    model_write(4'h0, 32'hA5A5A5A5, 4'hF);
    awaddr = 4'hC; wdata = 32'h00000077;
    for (int k = 0; k < 10; k++) begin
      check("bp_bvalid",  {31'd0, bvalid},  32'd1);
      check("bp_awready", {31'd0, awready}, 32'd0);
      check("bp_wready",  {31'd0, wready},  32'd0);
      @(negedge clk);
    end
    check("bp_reg3_held", reg3, m_reg[3]);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bp_awready_after", {31'd0, awready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(4'hC, 32'h00000077, 4'hF);
    check("bp_bvalid2", {31'd0, bvalid}, 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_regs("bp");

    // ---- read and write to same register on the same edge
    axi_write(4'h4, 32'h00000002, 4'hF);
    awaddr = 4'h4; wdata = 32'h00000055; wstrb = 4'hF;
    araddr = 4'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    exp_q.push_back(m_reg[1]);
    check("same_arready", {31'd0, arready}, 32'd1);
    check("same_awready", {31'd0, awready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(4'h4, 32'h00000055, 4'hF);
    check("same_rvalid", {31'd0, rvalid}, 32'd1);
    check("same_bvalid", {31'd0, bvalid}, 32'd1);
    check("same_rdata", rdata, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0);
    check("same_rdata_old", rdata, 32'h00000002);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    axi_read(4'h4);
    check("same_reg1", reg1, 32'h00000055);

    // ---- asynchronous reset with a read pending
    axi_write(4'h8, 32'h00000003, 4'hF);
    araddr = 4'h8; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check("arst_rvalid_pre", {31'd0, rvalid}, 32'd1);
    check("arst_rdata_pre", rdata, 32'h00000003);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
    check("arst_rvalid", {31'd0, rvalid}, 32'd0);
    check("arst_reg2", reg2, 32'h0);
    check("arst_arready", {31'd0, arready}, 32'd0);
    check_regs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_rel_pre", {31'd0, wready}, 32'd0);
    @(negedge clk);
    check("arst_rel_wready", {31'd0, wready}, 32'd1);
    check("arst_rel_rvalid", {31'd0, rvalid}, 32'd0);
    check("arst_rel_bvalid", {31'd0, bvalid}, 32'd0);
    axi_read(4'h8);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
